// File: rtl/i2c_slave_target_pkg.sv
// Shared definitions for the I2C target: FSM states and bus-level constants.
// Imported by the top level and available to the matching bus master.
package i2c_slave_target_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_WAIT_P
    } state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;
    localparam int   RW_BIT   = 0;

endpackage

// File: rtl/i2c_slave_target_line_filter.sv
// Synchroniser plus hold filter for one I2C line, with registered edge pulses.
// A new level is accepted only after FILT_LEN consecutive differing samples.
module i2c_slave_target_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic line,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(FILT_LEN + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   line_d;
    logic                   samp;

    assign samp = sync_q[SYNC_STAGES-1];

    always_comb begin
        line_d = line;
        cnt_d  = '0;
        if (samp != line) begin
            if (cnt_q == CW'(FILT_LEN - 1)) line_d = samp;
            else                            cnt_d  = cnt_q + 1'b1;
        end
    end

    // Idle bus level is high, so the chain resets to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            cnt_q  <= '0;
            line   <= 1'b1;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            cnt_q  <= cnt_d;
            line   <= line_d;
            rise   <= line_d & ~line;
            fall   <= ~line_d & line;
        end
    end

endmodule

// File: rtl/i2c_slave_target.sv
// Byte-oriented I2C target: START/STOP detection, 7-bit address match,
// write-byte reception and read-byte service over pulse handshakes.
module i2c_slave_target
    import i2c_slave_target_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILT_LEN    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rd_req,
    output logic       addr_hit,
    output logic       nack_rx,
    output logic       busy
);

    logic scl_l, scl_r, scl_f;
    logic sda_l, sda_r, sda_f;
    logic start_ev, stop_ev;

    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d, shift_in, rx_d;
    logic [3:0] cnt_q, cnt_d;
    logic       rw_q, rw_d;
    logic       oe_q, oe_d;
    logic       rxv_d, rdr_d, hit_d, nack_d;

    i2c_slave_target_line_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN)
    ) u_scl_filt (
        .clk  (clk),
        .rst_n(rst_n),
        .pin  (scl),
        .line (scl_l),
        .rise (scl_r),
        .fall (scl_f)
    );

    i2c_slave_target_line_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN)
    ) u_sda_filt (
        .clk  (clk),
        .rst_n(rst_n),
        .pin  (sda),
        .line (sda_l),
        .rise (sda_r),
        .fall (sda_f)
    );

    assign sda      = oe_q ? 1'b0 : 1'bz;
    assign start_ev = sda_f & scl_l;
    assign stop_ev  = sda_r & scl_l;
    assign shift_in = {shift_q[6:0], sda_l};
    assign busy     = (state_q != ST_IDLE) && (state_q != ST_ADDR);

    // In the ACK states cnt_q is a phase flag: 0 before, 1 during the ACK bit.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        oe_d    = oe_q;
        rx_d    = rx_data;
        rxv_d   = 1'b0;
        rdr_d   = 1'b0;
        hit_d   = 1'b0;
        nack_d  = 1'b0;
        if (stop_ev) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
            cnt_d   = '0;
        end else if (start_ev) begin
            state_d = ST_ADDR;
            oe_d    = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_ADDR: if (scl_r) begin
                    shift_d = shift_in;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d = '0;
                        if (shift_in[7:1] == SLAVE_ADDR) begin
                            state_d = ST_ADDR_ACK;
                            hit_d   = 1'b1;
                            rw_d    = shift_in[RW_BIT];
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_r && cnt_q == 4'd1 && rw_q) rdr_d = 1'b1;
                    if (scl_f) begin
                        if (cnt_q == 4'd0) begin
                            oe_d  = 1'b1;
                            cnt_d = 4'd1;
                        end else if (rw_q) begin
                            shift_d = tx_data;
                            oe_d    = ~tx_data[7];
                            cnt_d   = 4'd1;
                            state_d = ST_RD_BYTE;
                        end else begin
                            oe_d    = 1'b0;
                            cnt_d   = '0;
                            state_d = ST_WR_BYTE;
                        end
                    end
                end
                ST_WR_BYTE: if (scl_r) begin
                    shift_d = shift_in;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        rx_d    = shift_in;
                        rxv_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_WR_ACK;
                    end
                end
                ST_WR_ACK: if (scl_f) begin
                    if (cnt_q == 4'd0) begin
                        oe_d  = 1'b1;
                        cnt_d = 4'd1;
                    end else begin
                        oe_d    = 1'b0;
                        cnt_d   = '0;
                        state_d = ST_WR_BYTE;
                    end
                end
                // cnt_q counts bits already placed on the bus.
                ST_RD_BYTE: if (scl_f) begin
                    if (cnt_q == 4'd8) begin
                        oe_d    = 1'b0;
                        cnt_d   = '0;
                        state_d = ST_RD_ACK;
                    end else begin
                        shift_d = {shift_q[6:0], 1'b0};
                        oe_d    = ~shift_q[6];
                        cnt_d   = cnt_q + 4'd1;
                    end
                end
                ST_RD_ACK: begin
                    if (scl_r && cnt_q == 4'd0) begin
                        if (sda_l == I2C_ACK) begin
                            rdr_d = 1'b1;
                            cnt_d = 4'd1;
                        end else begin
                            nack_d  = 1'b1;
                            state_d = ST_WAIT_P;
                        end
                    end
                    if (scl_f && cnt_q == 4'd1) begin
                        shift_d = tx_data;
                        oe_d    = ~tx_data[7];
                        cnt_d   = 4'd1;
                        state_d = ST_RD_BYTE;
                    end
                end
                ST_WAIT_P: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            rw_q     <= 1'b0;
            oe_q     <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rd_req   <= 1'b0;
            addr_hit <= 1'b0;
            nack_rx  <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            rw_q     <= rw_d;
            oe_q     <= oe_d;
            rx_data  <= rx_d;
            rx_valid <= rxv_d;
            rd_req   <= rdr_d;
            addr_hit <= hit_d;
            nack_rx  <= nack_d;
        end
    end

endmodule

// File: tb/tb_i2c_slave_target.sv
// Bench for i2c_slave_target: bit-banged bus master, event scoreboard
// and a transaction-level model of what the target should do.
module tb_i2c_slave_target;

    localparam int Q = 15;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       scl     = 1'b1;
    logic       m_low   = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] rx_data;
    logic       rx_valid, rd_req, addr_hit, nack_rx, busy;
    wire        sda;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_slave_target dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .scl     (scl),
        .sda     (sda),
        .tx_data (tx_data),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rd_req  (rd_req),
        .addr_hit(addr_hit),
        .nack_rx (nack_rx),
        .busy    (busy)
    );

    typedef enum int {EV_HIT, EV_RX, EV_RDREQ, EV_NACK} ev_k_t;
    typedef struct {
        ev_k_t      k;
        logic [7:0] d;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] tx_src[$];
    logic [7:0] wbuf[4];
    logic [7:0] tbuf[4];
    bit         glitch_bit = 1'b0;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic expect_ev(input ev_k_t k, input logic [7:0] d);
        ev_t e;
        e.k = k;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Monitor: pops one expected event per observed pulse; also plays the
    // local logic that refreshes tx_data after every rd_req.
    always @(negedge clk) begin : monitor
        ev_t o;
        ev_t e;
        if (addr_hit || rx_valid || rd_req || nack_rx) begin
            o.k = addr_hit ? EV_HIT : rx_valid ? EV_RX :
                  rd_req ? EV_RDREQ : EV_NACK;
            o.d = rx_valid ? rx_data : 8'h00;
            if (rd_req && tx_src.size() > 0) tx_data = tx_src.pop_front();
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got kind %0d, none expected",
                         32'(o.k));
            end else begin
                e = exp_q.pop_front();
                chk("event_kind", 32'(o.k), 32'(e.k));
                if (e.k == EV_RX) chk("rx_data_event", 32'(o.d), 32'(e.d));
            end
        end
    end

    task automatic wq(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        m_low = 1'b0; wq(Q);
        scl   = 1'b1; wq(Q);
        m_low = 1'b1; wq(Q);
        scl   = 1'b0; wq(Q);
    endtask

    task automatic bus_stop();
        m_low = 1'b1; wq(Q);
        scl   = 1'b1; wq(Q);
        m_low = 1'b0; wq(Q);
    endtask

    task automatic put_bit(input bit b);
        m_low = !b;
        wq(5);
        if (glitch_bit) begin
            scl = 1'b1; wq(1);
            scl = 1'b0;
            glitch_bit = 1'b0;
        end
        wq(Q - 5);
        scl = 1'b1; wq(2 * Q);
        scl = 1'b0; wq(Q);
    endtask

    task automatic get_bit(output bit b);
        m_low = 1'b0; wq(Q);
        scl   = 1'b1; wq(Q);
        b     = sda;  wq(Q);
        scl   = 1'b0; wq(Q);
    endtask

    task automatic put_byte(input logic [7:0] v, output bit ack);
        for (int i = 7; i >= 0; i--) put_bit(v[i]);
        get_bit(ack);
    endtask

    task automatic get_byte(output logic [7:0] v);
        bit b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            v[i] = b;
        end
    endtask

    // One addressed transaction; expectations come from the bus rules only.
    task automatic xfer(input logic [6:0] a, input bit rw, input int n,
                        input int nsrc, input bit do_stop);
        bit         ack;
        logic [7:0] v;
        bit         hit;
        hit = (a == 7'h50);
        if (hit) begin
            expect_ev(EV_HIT, 8'h00);
            if (rw) expect_ev(EV_RDREQ, 8'h00);
        end
        if (rw && hit) for (int i = 0; i < nsrc; i++) tx_src.push_back(tbuf[i]);
        bus_start();
        put_byte({a, rw}, ack);
        chk("addr_ack", 32'(ack), hit ? 32'd0 : 32'd1);
        chk("busy_after_addr", 32'(busy), 32'(hit));
        if (!hit) begin
            bus_stop();
            return;
        end
        for (int i = 0; i < n; i++) begin
            if (!rw) begin
                expect_ev(EV_RX, wbuf[i]);
                put_byte(wbuf[i], ack);
                chk("data_ack", 32'(ack), 32'd0);
            end else begin
                get_byte(v);
                chk("rd_byte", 32'(v), 32'(tbuf[(i < nsrc) ? i : nsrc - 1]));
                if (i < n - 1) expect_ev(EV_RDREQ, 8'h00);
                else           expect_ev(EV_NACK, 8'h00);
                put_bit(i == n - 1);
            end
        end
        if (do_stop) begin
            bus_stop();
            wq(10);
            chk("busy_after_stop", 32'(busy), 32'd0);
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit ack;
        bit b;
        wq(5);
        chk("reset_rx_data", 32'(rx_data), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_sda", 32'(sda), 32'd1);
        chk("reset_pulses", 32'({rx_valid, rd_req, addr_hit, nack_rx}), 32'd0);
        rst_n = 1'b1;
        wq(20);

        wbuf[0] = 8'hA5;
        xfer(7'h50, 1'b0, 1, 0, 1'b1);
        chk("t1_rx_data", 32'(rx_data), 32'hA5);

        xfer(7'h51, 1'b0, 1, 0, 1'b1);

        tbuf[0] = 8'h3C;
        xfer(7'h50, 1'b1, 1, 1, 1'b1);

        tbuf[0] = 8'h01; tbuf[1] = 8'h02; tbuf[2] = 8'h03;
        xfer(7'h50, 1'b1, 3, 3, 1'b1);

        wbuf[0] = 8'h11;
        xfer(7'h50, 1'b0, 1, 0, 1'b0);
        tbuf[0] = 8'h5A;
        xfer(7'h50, 1'b1, 1, 1, 1'b1);
        chk("t5_rx_data", 32'(rx_data), 32'h11);

        glitch_bit = 1'b1;
        wbuf[0] = 8'hC3;
        xfer(7'h50, 1'b0, 1, 0, 1'b1);
        chk("glitch_rx_data", 32'(rx_data), 32'hC3);

        tbuf[0] = 8'h77;
        xfer(7'h50, 1'b1, 2, 1, 1'b1);

        // Reset while the target drives the 4th bit (a 0) of a read byte.
        expect_ev(EV_HIT, 8'h00);
        expect_ev(EV_RDREQ, 8'h00);
        tx_src.push_back(8'hE7);
        bus_start();
        put_byte({7'h50, 1'b1}, ack);
        chk("t6_addr_ack", 32'(ack), 32'd0);
        for (int i = 0; i < 3; i++) get_bit(b);
        chk("t6_drive_bit4", 32'(sda), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("t6_sda_released", 32'(sda), 32'd1);
        chk("t6_rx_data", 32'(rx_data), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_pulses", 32'({rx_valid, rd_req, addr_hit, nack_rx}), 32'd0);
        wq(3);
        rst_n = 1'b1;
        wq(20);
        bus_stop();
        wq(10);

        wbuf[0] = 8'h96;
        xfer(7'h50, 1'b0, 1, 0, 1'b1);
        chk("t6_after_rx_data", 32'(rx_data), 32'h96);

        repeat (10) begin
            logic [6:0] a;
            bit         rw;
            int         n;
            a  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h50;
            rw = 1'($urandom);
            n  = $urandom_range(1, 3);
            for (int i = 0; i < 4; i++) begin
                wbuf[i] = 8'($urandom);
                tbuf[i] = 8'($urandom);
            end
            xfer(a, rw, n, n, 1'b1);
        end

        wq(20);
        chk("events_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
